// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared addresses, state encoding and source-page mapping for the OAM DMA block
package oam_dma_pkg;
   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [15:0] OAM_BASE     = 16'hFE00;
   localparam logic [15:0] HRAM_BASE    = 16'hFF80;
   localparam logic [7:0]  ECHO_BASE_HI = 8'hE0;
   typedef enum logic [1:0] {IDLE, START, XFER} state_t;
   // Pages E0-FF mirror work RAM at C0-DF
   function automatic logic [7:0] src_page(input logic [7:0] v);
      return (v < ECHO_BASE_HI) ? v : v - 8'h20;
   endfunction
endpackage

// File: rtl/oam_dma.sv
// oam_dma: FF46 register and bus master copying one 160-byte page into OAM, one byte per M-cycle
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter int BYTE_CLKS   = 4,
   parameter int XFER_LEN    = 160,
   parameter int START_DELAY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_wr,
   input  logic        cpu_rd,
   output logic [7:0]  reg_dout,
   output logic [15:0] dma_a,
   output logic        dma_rd,
   output logic        dma_wr,
   output logic [7:0]  dma_dout,
   input  logic [7:0]  dma_din,
   output logic        active,
   output logic        cpu_grant
);
   localparam int PW = $clog2(BYTE_CLKS);
   localparam int CW = $clog2(START_DELAY) + 1;
   localparam logic [PW-1:0] HALF_LAST = PW'(BYTE_CLKS / 2 - 1);
   localparam logic [PW-1:0] LAST      = PW'(BYTE_CLKS - 1);
   localparam logic [7:0]    IDX_LAST  = 8'(XFER_LEN - 1);
   localparam logic [CW-1:0] CNT_INIT  = CW'(START_DELAY - 1);
   state_t          state;
   logic [7:0]      src_hi;
   logic [7:0]      idx;
   logic [PW-1:0]   phase;
   logic [CW-1:0]   cnt;
   logic            reg_wr;
   logic            unused_rd;
   assign reg_wr    = cpu_wr && cpu_a == DMA_REG_ADDR;
   assign cpu_grant = !active || cpu_a >= HRAM_BASE || cpu_a == DMA_REG_ADDR;
   // FF46 reads are served straight from reg_dout by the bus mux
   assign unused_rd = cpu_rd;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         reg_dout <= 8'h00;
         src_hi   <= 8'h00;
         idx      <= 8'h00;
         phase    <= '0;
         cnt      <= '0;
         dma_a    <= 16'h0000;
         dma_rd   <= 1'b0;
         dma_wr   <= 1'b0;
         dma_dout <= 8'h00;
         active   <= 1'b0;
      end else if (reg_wr) begin
         reg_dout <= cpu_dout;
         src_hi   <= src_page(cpu_dout);
         state    <= START;
         cnt      <= CNT_INIT;
         active   <= 1'b1;
         dma_rd   <= 1'b0;
         dma_wr   <= 1'b0;
      end else begin
         case (state)
            START: begin
               if (cnt == '0) begin
                  state  <= XFER;
                  idx    <= 8'h00;
                  phase  <= '0;
                  dma_a  <= {src_hi, 8'h00};
                  dma_rd <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            XFER: begin
               if (phase == HALF_LAST) dma_dout <= dma_din;
               if (phase == LAST) begin
                  phase <= '0;
                  if (idx == IDX_LAST) begin
                     state  <= IDLE;
                     idx    <= 8'h00;
                     active <= 1'b0;
                     dma_rd <= 1'b0;
                     dma_wr <= 1'b0;
                  end else begin
                     idx    <= idx + 8'd1;
                     dma_a  <= {src_hi, idx + 8'd1};
                     dma_rd <= 1'b1;
                     dma_wr <= 1'b0;
                  end
               end else begin
                  phase <= phase + 1'b1;
                  if (phase == HALF_LAST) begin
                     dma_a  <= OAM_BASE + {8'h00, idx};
                     dma_rd <= 1'b0;
                     dma_wr <= 1'b1;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               active <= 1'b0;
               dma_rd <= 1'b0;
               dma_wr <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized page copies checked against a page-level model of memory and OAM
module tb_oam_dma;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_dout;
   logic        cpu_wr;
   logic        cpu_rd;
   logic [7:0]  reg_dout;
   logic [15:0] dma_a;
   logic        dma_rd;
   logic        dma_wr;
   logic [7:0]  dma_dout;
   logic [7:0]  dma_din;
   logic        active;
   logic        cpu_grant;
   int total = 0;
   int bad = 0;
   logic [7:0] mem [65536];
   logic [7:0] oam [160];
   int wr_time [160] = '{default: -1};
   int cyc = 0;
   int both = 0;
   int oob = 0;
   int rd_bad = 0;
   logic [7:0] exp_hi = 8'h00;

   oam_dma dut (
      .clk(clk), .rst(rst), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
      .reg_dout(reg_dout), .dma_a(dma_a), .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_dout(dma_dout),
      .dma_din(dma_din), .active(active), .cpu_grant(cpu_grant)
   );

   always #5 clk = ~clk;
   assign dma_din = mem[dma_a];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         if (dma_rd && dma_wr) both <= both + 1;
         if (dma_rd && dma_a[15:8] != exp_hi) rd_bad <= rd_bad + 1;
         if (dma_wr) begin
            if (dma_a >= 16'hFE00 && dma_a < 16'hFEA0) begin
               oam[dma_a[7:0]] <= dma_dout;
               wr_time[dma_a[7:0]] <= cyc;
            end else oob <= oob + 1;
         end
      end
   end

   function automatic logic [7:0] phys(input logic [7:0] v);
      return (v >= 8'hE0) ? v - 8'h20 : v;
   endfunction

   function automatic int oam_errs(input logic [7:0] hi, input int since);
      int e = 0;
      for (int i = 0; i < 160; i++)
         if (oam[i] !== mem[{hi, 8'(i)}] || wr_time[i] < since) e++;
      return e;
   endfunction

   task automatic fill(input logic [7:0] hi);
      for (int i = 0; i < 160; i++) mem[{hi, 8'(i)}] = 8'($urandom);
   endtask

   task automatic cpu_write(input logic [7:0] v);
      cpu_a = 16'hFF46;
      cpu_dout = v;
      cpu_wr = 1'b1;
      @(negedge clk);
      cpu_wr = 1'b0;
      cpu_a = 16'h0000;
   endtask

   task automatic measure(output int len, output int first_rd, output logic [15:0] first_a);
      int k = 0;
      first_rd = -1;
      first_a = 16'h0000;
      while (active && k < 2000) begin
         if (dma_rd && first_rd < 0) begin
            first_rd = k;
            first_a = dma_a;
         end
         @(negedge clk);
         k++;
      end
      len = k;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      cpu_a = 16'hFF46;
      cpu_dout = 8'hAB;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cpu_wr = ~cpu_wr;
      end
      cpu_wr = 1'b0;
      cpu_a = 16'h1234;
      #1;
      total++; if ({active, dma_rd, dma_wr} !== 3'b000) begin bad++; $display("FAIL reset_ctrl act/rd/wr=%b want 000", {active, dma_rd, dma_wr}); end
      total++; if (dma_a !== 16'h0000) begin bad++; $display("FAIL reset_dma_a got=%h want 0000", dma_a); end
      total++; if (dma_dout !== 8'h00 || reg_dout !== 8'h00) begin bad++; $display("FAIL reset_data dout=%h reg=%h want 00", dma_dout, reg_dout); end
      total++; if (cpu_grant !== 1'b1) begin bad++; $display("FAIL reset_grant got=%b want 1", cpu_grant); end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_idle active=%b want 0", active); end
   endtask

   task automatic test_basic;
      int len, fr, t0;
      logic [15:0] fa;
      for (int i = 0; i < 160; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      exp_hi = 8'hC0;
      t0 = cyc;
      cpu_write(8'hC0);
      total++; if (active !== 1'b1) begin bad++; $display("FAIL basic_active_rise got=%b want 1", active); end
      measure(len, fr, fa);
      total++; if (fr !== 4 || fa !== 16'hC000) begin bad++; $display("FAIL basic_first_rd at=%0d addr=%h want 4 C000", fr, fa); end
      total++; if (len !== 644) begin bad++; $display("FAIL basic_busy got=%0d want 644", len); end
      total++; if (oam_errs(8'hC0, t0) !== 0) begin bad++; $display("FAIL basic_oam bad_bytes=%0d want 0", oam_errs(8'hC0, t0)); end
      total++; if (reg_dout !== 8'hC0) begin bad++; $display("FAIL basic_reg got=%h want C0", reg_dout); end
   endtask

   task automatic test_blocking;
      int len, fr;
      logic [15:0] fa;
      logic [15:0] addrs [5] = '{16'h8000, 16'hFF80, 16'hFF46, 16'hFFFF, 16'hFF7F};
      logic        want [5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      fill(8'h12);
      exp_hi = 8'h12;
      cpu_write(8'h12);
      repeat (100) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         cpu_a = addrs[i];
         #1;
         total++; if (cpu_grant !== want[i]) begin bad++; $display("FAIL block_grant a=%h got=%b want %b", addrs[i], cpu_grant, want[i]); end
      end
      cpu_a = 16'h0000;
      measure(len, fr, fa);
      cpu_a = 16'h8000;
      #1;
      total++; if (cpu_grant !== 1'b1) begin bad++; $display("FAIL block_after got=%b want 1", cpu_grant); end
      cpu_a = 16'h0000;
   endtask

   task automatic test_copy(input logic [7:0] v);
      int len, fr, t0;
      logic [15:0] fa;
      fill(phys(v));
      exp_hi = phys(v);
      t0 = cyc;
      cpu_write(v);
      measure(len, fr, fa);
      total++; if (fr !== 4 || fa !== {phys(v), 8'h00}) begin bad++; $display("FAIL copy_%h_first_rd at=%0d addr=%h want 4 %h00", v, fr, fa, phys(v)); end
      total++; if (len !== 644) begin bad++; $display("FAIL copy_%h_busy got=%0d want 644", v, len); end
      total++; if (oam_errs(phys(v), t0) !== 0) begin bad++; $display("FAIL copy_%h_oam bad_bytes=%0d want 0", v, oam_errs(phys(v), t0)); end
      total++; if (reg_dout !== v) begin bad++; $display("FAIL copy_%h_reg got=%h want %h", v, reg_dout, v); end
   endtask

   task automatic test_restart;
      int len, fr, t1;
      logic [15:0] fa;
      fill(8'hC0);
      for (int i = 0; i < 160; i++) mem[16'hD000 + 16'(i)] = ~mem[16'hC000 + 16'(i)];
      exp_hi = 8'hC0;
      cpu_write(8'hC0);
      repeat (44) @(negedge clk);
      cpu_write(8'hD0);
      exp_hi = 8'hD0;
      t1 = cyc;
      total++; if (dma_rd !== 1'b0 || dma_wr !== 1'b0 || active !== 1'b1) begin bad++; $display("FAIL restart_start rd=%b wr=%b act=%b want 0 0 1", dma_rd, dma_wr, active); end
      measure(len, fr, fa);
      total++; if (fr !== 4 || fa !== 16'hD000) begin bad++; $display("FAIL restart_first_rd at=%0d addr=%h want 4 D000", fr, fa); end
      total++; if (len !== 644) begin bad++; $display("FAIL restart_busy got=%0d want 644", len); end
      total++; if (oam_errs(8'hD0, t1) !== 0) begin bad++; $display("FAIL restart_oam bad_bytes=%0d want 0", oam_errs(8'hD0, t1)); end
   endtask

   task automatic test_back_to_back;
      int len, fr, t1;
      logic [15:0] fa;
      logic [7:0] p1, p2;
      p1 = 8'($urandom_range(0, 255));
      p2 = p1 ^ 8'h10;
      fill(phys(p1));
      fill(phys(p2));
      exp_hi = phys(p1);
      cpu_write(p1);
      repeat (643) @(negedge clk);
      total++; if (active !== 1'b1) begin bad++; $display("FAIL b2b_last_slot active=%b want 1", active); end
      cpu_write(p2);
      exp_hi = phys(p2);
      t1 = cyc;
      total++; if (active !== 1'b1) begin bad++; $display("FAIL b2b_restart active=%b want 1", active); end
      measure(len, fr, fa);
      total++; if (len !== 644 || fr !== 4) begin bad++; $display("FAIL b2b_timing busy=%0d first_rd=%0d want 644 4", len, fr); end
      total++; if (oam_errs(phys(p2), t1) !== 0) begin bad++; $display("FAIL b2b_oam bad_bytes=%0d want 0", oam_errs(phys(p2), t1)); end
   endtask

   task automatic test_reset_mid;
      int k = 0, t0, e = 0, busy = 0;
      fill(8'h40);
      exp_hi = 8'h40;
      t0 = cyc;
      cpu_write(8'h40);
      while (!(dma_rd && dma_a[7:0] == 8'd50) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      total++; if (k >= 1000) begin bad++; $display("FAIL midreset_reach timeout k=%0d want byte 50", k); end
      #2 rst = 1'b0;
      #1;
      total++; if ({active, dma_rd, dma_wr} !== 3'b000) begin bad++; $display("FAIL midreset_async act/rd/wr=%b want 000", {active, dma_rd, dma_wr}); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (active || dma_rd || dma_wr) busy++;
      end
      total++; if (busy !== 0) begin bad++; $display("FAIL midreset_idle busy_cycles=%0d want 0", busy); end
      for (int i = 0; i < 160; i++)
         if ((i < 50) ? (wr_time[i] < t0 || oam[i] !== mem[{8'h40, 8'(i)}]) : (wr_time[i] >= t0)) e++;
      total++; if (e !== 0) begin bad++; $display("FAIL midreset_oam bad_bytes=%0d want 0", e); end
   endtask

   task automatic test_bus_rules;
      total++; if (both !== 0) begin bad++; $display("FAIL rules_rd_and_wr got=%0d want 0", both); end
      total++; if (oob !== 0) begin bad++; $display("FAIL rules_wr_range got=%0d want 0", oob); end
      total++; if (rd_bad !== 0) begin bad++; $display("FAIL rules_src_page got=%0d want 0", rd_bad); end
   endtask

   initial begin
      rst = 1'b0;
      cpu_a = 16'h0000;
      cpu_dout = 8'h00;
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
      test_reset;
      test_basic;
      test_blocking;
      test_copy(8'hF1);
      for (int i = 0; i < 3; i++) test_copy(8'($urandom_range(0, 255)));
      test_restart;
      test_back_to_back;
      test_reset_mid;
      test_bus_rules;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
